demux_router: RTL

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_router_pkg.sv | 19 +
 rtl/demux_slot.sv | 63 ++++++
 rtl/demux_router.sv | 75 +++++++
 3 files changed

// File: rtl/demux_router_pkg.sv
// rtl/demux_router_pkg.sv - shared channel count, channel index type and slot state encoding
package demux_router_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Channel index as seen by the router: s0 is the MSB.
  function automatic ch_idx_t ch_index(input logic s0, input logic s1);
    return {s0, s1};
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output slot with optional delivered counter (DEMUX_ROUTER_COUNT_EN)
module demux_slot
  import demux_router_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic             ready,
  output logic [W-1:0]     data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  slot_state_t state;

  assign valid = (state == SLOT_FULL);

  // Slot state and data: a load always wins, so drain+refill keeps the slot full with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (load) begin
            state <= SLOT_FULL;
            data  <= load_data;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            data <= load_data;
          end else if (ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

`ifdef DEMUX_ROUTER_COUNT_EN
  logic [CNT_W-1:0] count_q;

  assign count = count_q;

  // Delivered-word counter; wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (valid && ready) begin
      count_q <= count_q + 1'b1;
    end
  end
`else
  assign count = '0;
`endif

endmodule

// File: rtl/demux_router.sv
// rtl/demux_router.sv - 1-to-4 demux router with per-channel slots; counters under DEMUX_ROUTER_COUNT_EN
module demux_router
  import demux_router_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         s0,
  input  logic         s1,
  output logic [W-1:0] d0,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic [W-1:0] d3,
  output logic         v0,
  output logic         v1,
  output logic         v2,
  output logic         v3,
  input  logic         r0,
  input  logic         r1,
  input  logic         r2,
  input  logic         r3,
  output logic [31:0]  cnt
);

  ch_idx_t           sel;
  logic [NUM_CH-1:0] v_vec;
  logic [NUM_CH-1:0] r_vec;
  logic [NUM_CH-1:0] load_vec;
  logic              accept;
  logic [W-1:0]      d_arr   [NUM_CH];
  logic [CNT_W-1:0]  cnt_arr [NUM_CH];

  assign sel   = ch_index(s0, s1);
  assign r_vec = {r3, r2, r1, r0};

  // The selected slot can take a word if it is empty or is being drained this cycle.
  assign in_ready = !v_vec[sel] || r_vec[sel];
  assign accept   = in_valid && in_ready;

  // Decode the accepted transfer onto exactly one slot's load strobe.
  always_comb begin
    load_vec = '0;
    if (accept) begin
      load_vec[sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load_vec[k]),
      .load_data (in_data),
      .ready     (r_vec[k]),
      .data      (d_arr[k]),
      .valid     (v_vec[k]),
      .count     (cnt_arr[k])
    );
    assign cnt[CNT_W*k +: CNT_W] = cnt_arr[k];
  end

  assign d0 = d_arr[0];
  assign d1 = d_arr[1];
  assign d2 = d_arr[2];
  assign d3 = d_arr[3];
  assign v0 = v_vec[0];
  assign v1 = v_vec[1];
  assign v2 = v_vec[2];
  assign v3 = v_vec[3];

endmodule
